// File: rtl/cpu_pkg.sv
// Shared types for the register-file write-port arbiter: write-source tag,
// default widths, and the long-latency result entry layout.
package cpu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef enum logic [1:0] {WB_NONE, WB_PIPE, WB_LU} wb_src_t;

  typedef struct packed {
    logic [AW_DEF-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } lu_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding long-latency results; exposes all entries plus
// a valid vector so the arbiter can answer pending-destination queries.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [CW-1:0]             count,
  output logic [W-1:0]              head,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          valid
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           off;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = din;
    // power-of-two depth lets the pointers wrap by plain overflow
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    off   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr_q;
      valid[i] = {1'b0, off} < count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign entries = mem_q;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && count_q == '0));
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback stage wins, queued long-latency
// results drain on idle cycles, and an age counter requests a bubble.
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int AW       = AW_DEF,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            lu_valid,
  input  logic [AW-1:0]   lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            wb_stall_req,
  input  logic [AW-1:0]   chk_rd,
  output logic            chk_hit
);
  localparam int W   = AW + XLEN;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int AGW = $clog2(MAX_WAIT + 1);

  logic                    pipe_wr, empty, push, pop;
  logic [CW-1:0]           fifo_count;
  logic [W-1:0]            head;
  logic [DEPTH-1:0][W-1:0] entries;
  logic [DEPTH-1:0]        valid;
  wb_src_t                 wb_src;
  logic [AGW-1:0]          age_q, age_d;
  logic                    stall_q, stall_d;

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din({lu_rd, lu_data}),
    .count(fifo_count), .head(head), .entries(entries), .valid(valid)
  );

  always_comb begin
    pipe_wr  = RegWriteW && (RdW != '0);
    empty    = (fifo_count == '0);
    // readiness looks only at the registered count, never at a same-cycle pop
    lu_ready = !reset && (fifo_count < CW'(DEPTH));
    push     = lu_valid && lu_ready && (lu_rd != '0);
    wb_src   = pipe_wr ? WB_PIPE : (!empty ? WB_LU : WB_NONE);
    pop      = (wb_src == WB_LU);

    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    case (wb_src)
      WB_PIPE: begin rf_we = 1'b1; rf_wa = RdW;            rf_wd = ResultW;          end
      WB_LU:   begin rf_we = 1'b1; rf_wa = head[W-1 -: AW]; rf_wd = head[XLEN-1:0]; end
      default: ;
    endcase

    // non-empty and not popping means the head is blocked by the pipeline
    if (empty || pop)                   age_d = '0;
    else if (age_q != AGW'(MAX_WAIT))   age_d = age_q + 1'b1;
    else                                age_d = age_q;
    stall_d = (age_d == AGW'(MAX_WAIT));

    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && entries[i][W-1 -: AW] == chk_rd) chk_hit = 1'b1;
    chk_hit = chk_hit && (chk_rd != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  assign wb_stall_req = stall_q;

  a_no_x0_write: assert property (@(posedge clk) disable iff (reset) !(rf_we && rf_wa == '0));
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_wb_port_arbiter;
  localparam int XLEN = 32, AW = 5, DEPTH = 2, MAXW = 4;

  logic            clk = 0, reset = 0;
  logic            RegWriteW = 0, lu_valid = 0;
  logic [AW-1:0]   RdW = 0, lu_rd = 0, chk_rd = 0;
  logic [XLEN-1:0] ResultW = 0, lu_data = 0;
  logic            lu_ready, rf_we, wb_stall_req, chk_hit;
  logic [AW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;

  wb_port_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .wb_stall_req(wb_stall_req),
    .chk_rd(chk_rd), .chk_hit(chk_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: pending results as a queue, age as a plain integer
  typedef struct { logic [AW-1:0] rd; logic [XLEN-1:0] data; } ent_t;
  ent_t mq[$];
  int   m_age = 0;
  bit   m_stall = 0;
  logic [AW-1:0] lu_log[$];

  always @(posedge clk or posedge reset) begin
    bit pw, popped;
    int pre, na;
    bit ns;
    if (reset) begin
      mq.delete();
      m_age   <= 0;
      m_stall <= 0;
    end else begin
      pw     = RegWriteW && (RdW != 0);
      pre    = mq.size();
      popped = !pw && pre > 0;
      if (popped) void'(mq.pop_front());
      if (lu_valid && pre < DEPTH && lu_rd != 0) mq.push_back('{lu_rd, lu_data});
      na = (pre == 0 || popped) ? 0 : ((m_age < MAXW) ? m_age + 1 : MAXW);
      ns = popped ? 1'b0 : ((na == MAXW) ? 1'b1 : m_stall);
      m_age   <= na;
      m_stall <= ns;
    end
  end

  always @(negedge clk) begin
    bit pw, ewe, hit;
    logic [AW-1:0] ewa;
    logic [XLEN-1:0] ewd;
    pw = RegWriteW && (RdW != 0);
    ewe = 1; ewa = 0; ewd = 0;
    if (pw) begin ewa = RdW; ewd = ResultW; end
    else if (mq.size() > 0) begin ewa = mq[0].rd; ewd = mq[0].data; end
    else ewe = 0;
    hit = 0;
    if (chk_rd != 0) foreach (mq[i]) if (mq[i].rd == chk_rd) hit = 1;
    check("model rf_we", rf_we, ewe);
    check("model rf_wa", rf_wa, ewa);
    check("model rf_wd", rf_wd, ewd);
    check("model lu_ready", lu_ready, !reset && mq.size() < DEPTH);
    check("model wb_stall_req", wb_stall_req, m_stall);
    check("model chk_hit", chk_hit, hit);
    if (rf_we && !pw) lu_log.push_back(rf_wa);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #1 reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rf_we", rf_we, 0);
    check("reset lu_ready", lu_ready, 0);
    check("reset stall", wb_stall_req, 0);
    check("reset chk_hit", chk_hit, 0);
    cyc(); reset = 0;

    // 1: single result on an idle pipeline
    lu_valid = 1; lu_rd = 7; lu_data = 32'hDEADBEEF; settle();
    check("t1 lu_ready", lu_ready, 1);
    check("t1 no bypass", rf_we, 0);
    cyc(); lu_valid = 0; settle();
    check("t1 rf_we", rf_we, 1);
    check("t1 rf_wa", rf_wa, 7);
    check("t1 rf_wd", rf_wd, 32'hDEADBEEF);
    cyc(); settle();
    check("t1 drained", rf_we, 0);

    // 2: pipeline busy every cycle, aging and bubble request
    RegWriteW = 1; RdW = 3; ResultW = 32'h33;
    lu_valid = 1; lu_rd = 5; lu_data = 32'h55;
    cyc(); lu_rd = 6; lu_data = 32'h66; settle();
    check("t2 ready 2nd", lu_ready, 1);
    cyc(); lu_valid = 0; settle();
    check("t2 full ready", lu_ready, 0);
    check("t2 stall b1", wb_stall_req, 0);
    cyc(); check("t2 stall b2", wb_stall_req, 0);
    cyc(); check("t2 stall b3", wb_stall_req, 0);
    cyc(); check("t2 stall b4", wb_stall_req, 1);
    RegWriteW = 0; settle();
    check("t2 drain wa", rf_wa, 5);
    check("t2 drain wd", rf_wd, 32'h55);
    cyc(); check("t2 stall clr", wb_stall_req, 0);
    RegWriteW = 1;
    cyc(); check("t2 age restart", wb_stall_req, 0);
    RegWriteW = 0; settle();
    check("t2 second wa", rf_wa, 6);
    cyc(); settle();
    check("t2 empty", rf_we, 0);

    // 3: full FIFO with same-cycle pop, ordering across pointer wrap
    lu_log.delete();
    RegWriteW = 1; lu_valid = 1; lu_rd = 8; lu_data = 32'h80;
    cyc(); lu_rd = 9; lu_data = 32'h90;
    cyc(); RegWriteW = 0; lu_rd = 10; lu_data = 32'hA0; settle();
    check("t3 full pop ready", lu_ready, 0);
    check("t3 pop head", rf_wa, 8);
    cyc(); RegWriteW = 1; settle();
    check("t3 ready next", lu_ready, 1);
    cyc(); RegWriteW = 0; lu_rd = 11; lu_data = 32'hB0;
    cyc(); cyc(); lu_rd = 12; lu_data = 32'hC0;
    cyc(); lu_valid = 0;
    cyc(); cyc(); settle();
    check("t3 log size", lu_log.size(), 5);
    for (int i = 0; i < 5 && i < lu_log.size(); i++)
      check("t3 order", lu_log[i], 8 + i);

    // 4: rd=0 result discarded; RdW=0 does not occupy the port
    lu_valid = 1; lu_rd = 0; lu_data = 32'h1234; settle();
    check("t4 rd0 ready", lu_ready, 1);
    cyc(); lu_valid = 0; settle();
    check("t4 rd0 no write", rf_we, 0);
    lu_valid = 1; lu_rd = 4; lu_data = 32'h44; RegWriteW = 1; RdW = 3;
    cyc(); lu_valid = 0; RdW = 0; settle();
    check("t4 x0 drain we", rf_we, 1);
    check("t4 x0 drain wa", rf_wa, 4);
    check("t4 x0 drain wd", rf_wd, 32'h44);
    cyc(); RegWriteW = 0; RdW = 3; settle();
    check("t4 empty", rf_we, 0);

    // 5: pending-destination query
    lu_valid = 1; lu_rd = 9; lu_data = 32'h99; RegWriteW = 1;
    cyc(); lu_valid = 0; chk_rd = 9; settle();
    check("t5 hit", chk_hit, 1);
    chk_rd = 0; settle();
    check("t5 x0 nohit", chk_hit, 0);
    chk_rd = 9; RegWriteW = 0; settle();
    check("t5 hit while writing", chk_hit, 1);
    check("t5 write rd9", rf_wa, 9);
    cyc(); settle();
    check("t5 hit falls", chk_hit, 0);

    // 6: asynchronous reset with queued results and a pending bubble
    RegWriteW = 1; lu_valid = 1; lu_rd = 20; lu_data = 32'h200;
    cyc(); lu_rd = 21; lu_data = 32'h210;
    cyc(); lu_valid = 0;
    repeat (3) cyc();
    check("t6 stall set", wb_stall_req, 1);
    @(negedge clk); #1;
    reset = 1; RegWriteW = 0; chk_rd = 20; settle();
    check("t6 rst stall", wb_stall_req, 0);
    check("t6 rst ready", lu_ready, 0);
    check("t6 rst no write", rf_we, 0);
    check("t6 rst chk_hit", chk_hit, 0);
    cyc(); cyc(); reset = 0; settle();
    check("t6 ready after", lu_ready, 1);
    check("t6 no write after", rf_we, 0);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
